// File: rtl/pad_attr_ctrl.sv
// Pad attribute controller: per-pad WARL-legalised attribute words with settle-delayed write responses.
// Optional feature: define PAD_ATTR_CTRL_PARITY_EN for per-word even parity and a sticky parity_err_o.
module pad_attr_ctrl #(
    parameter int NumPads      = 16,
    parameter int AttrDw       = 13,
    parameter int SettleCycles = 4,
    parameter int IdxW         = (NumPads > 1) ? $clog2(NumPads) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [IdxW-1:0]           req_idx_i,
    input  logic [AttrDw-1:0]         req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [AttrDw-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    input  logic [NumPads*AttrDw-1:0] warl_mask_i,
    output logic [NumPads*AttrDw-1:0] attr_o,
`ifdef PAD_ATTR_CTRL_PARITY_EN
    output logic                      parity_err_o,
`endif
    output logic                      attr_busy_o
);

    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic even_par(input logic [AttrDw-1:0] word);
        return ^word;
    endfunction

    state_t              state_r;
    logic [CntW-1:0]     cnt_r;
    logic                ready_r;
    logic                rsp_valid_r;
    logic [AttrDw-1:0]   rsp_rdata_r;
    logic                rsp_err_r;
    logic                busy_r;
    logic [AttrDw-1:0]   pend_r;
    logic [AttrDw-1:0]   attr_r [NumPads];

    logic                accept_s;
    logic                idx_ok_s;
    logic                we_s;
    logic                rd_err_s;
    logic [AttrDw-1:0]   sel_word_s;
    logic [AttrDw-1:0]   sel_mask_s;
    logic [AttrDw-1:0]   legal_s;

`ifdef PAD_ATTR_CTRL_PARITY_EN
    logic [NumPads-1:0]  attr_par_r;
    logic                parity_err_r;
    logic                sel_par_s;
`endif

    // Decode the addressed pad; full-width compare keeps non-power-of-two pad counts safe
    always_comb begin
        accept_s   = req_valid_i & ready_r;
        idx_ok_s   = ({1'b0, req_idx_i} < (IdxW+1)'(NumPads));
        sel_word_s = {AttrDw{1'b0}};
        sel_mask_s = {AttrDw{1'b0}};
`ifdef PAD_ATTR_CTRL_PARITY_EN
        sel_par_s  = 1'b0;
`endif
        for (int i = 0; i < NumPads; i++) begin
            sel_word_s = (req_idx_i == IdxW'(i)) ? attr_r[i] : sel_word_s;
            sel_mask_s = (req_idx_i == IdxW'(i)) ? warl_mask_i[i*AttrDw +: AttrDw] : sel_mask_s;
`ifdef PAD_ATTR_CTRL_PARITY_EN
            sel_par_s  = (req_idx_i == IdxW'(i)) ? attr_par_r[i] : sel_par_s;
`endif
        end
        legal_s = req_wdata_i & sel_mask_s;
        we_s    = (state_r == IDLE) & accept_s & idx_ok_s & req_write_i;
`ifdef PAD_ATTR_CTRL_PARITY_EN
        rd_err_s = (sel_par_s != even_par(sel_word_s));
`else
        rd_err_s = 1'b0;
`endif
    end

    // Attribute word storage, written only with the legalised word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumPads; i++) begin
                attr_r[i] <= {AttrDw{1'b0}};
            end
        end else begin
            for (int i = 0; i < NumPads; i++) begin
                if (we_s && (req_idx_i == IdxW'(i))) begin
                    attr_r[i] <= legal_s;
                end
            end
        end
    end

`ifdef PAD_ATTR_CTRL_PARITY_EN
    // Parity bits track each stored word; a bad read latches parity_err_r until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            attr_par_r   <= {NumPads{1'b0}};
            parity_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NumPads; i++) begin
                if (we_s && (req_idx_i == IdxW'(i))) begin
                    attr_par_r[i] <= even_par(legal_s);
                end
            end
            if ((state_r == IDLE) && accept_s && idx_ok_s && !req_write_i && rd_err_s) begin
                parity_err_r <= 1'b1;
            end
        end
    end

    assign parity_err_o = parity_err_r;
`endif

    // Request/settle/response sequencing with registered handshake outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            cnt_r       <= {CntW{1'b0}};
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {AttrDw{1'b0}};
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            pend_r      <= {AttrDw{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ready_r <= 1'b0;
                        if (!idx_ok_s) begin
                            rsp_rdata_r <= {AttrDw{1'b0}};
                            rsp_err_r   <= 1'b1;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end else if (req_write_i) begin
                            pend_r  <= legal_s;
                            busy_r  <= 1'b1;
                            cnt_r   <= CntW'(SettleCycles - 1);
                            state_r <= SETTLE;
                        end else begin
                            rsp_rdata_r <= sel_word_s;
                            rsp_err_r   <= rd_err_s;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_r == {CntW{1'b0}}) begin
                        busy_r      <= 1'b0;
                        rsp_rdata_r <= pend_r;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CntW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        ready_r     <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NumPads; g++) begin : g_attr_out
        assign attr_o[g*AttrDw +: AttrDw] = attr_r[g];
    end

    assign req_ready_o = ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign attr_busy_o = busy_r;

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Scoreboard bench for pad_attr_ctrl with 12 pads (non-power-of-two index range).
module tb_pad_attr_ctrl;

    localparam int NP = 12;
    localparam int DW = 13;
    localparam int IW = 4;
    localparam int SC = 4;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_write;
    logic [IW-1:0]     req_idx;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic [NP*DW-1:0]  warl_mask;
    logic [NP*DW-1:0]  attr;
    logic              attr_busy;
`ifdef PAD_ATTR_CTRL_PARITY_EN
    logic              parity_err;
`endif

    exp_t          exp_q[$];
    logic [DW-1:0] model [NP];
    int            checks = 0;
    int            errors = 0;

    pad_attr_ctrl #(.NumPads(NP), .AttrDw(DW), .SettleCycles(SC)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_idx_i(req_idx), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .warl_mask_i(warl_mask), .attr_o(attr),
`ifdef PAD_ATTR_CTRL_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .attr_busy_o(attr_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] attr_word(input int i);
        return attr[i*DW +: DW];
    endfunction

    task automatic check_attr_all(input string name);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("%s attr[%0d]", name, i), 32'(attr_word(i)), 32'(model[i]));
        end
    endtask

    task automatic set_mask(input int i, input logic [DW-1:0] m);
        warl_mask[i*DW +: DW] = m;
    endtask

    // Issue one request, push its expected response, check latency/busy, then handshake after 'hold' cycles
    task automatic do_req(input logic wr, input logic [IW-1:0] idx, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_lat,
                          input int hold, input string name);
        int n;
        int busy_n;
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        exp_q.push_back({exp_rd, exp_err});
        req_valid = 1'b1; req_write = wr; req_idx = idx; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = '0;
        if (wr && !exp_err) model[idx] = exp_rd;
        if (wr) check_attr_all({name, " accept"});
        n = 1;
        busy_n = 0;
        while (!rsp_valid && n < 30) begin
            busy_n += int'(attr_busy);
            @(posedge clk); #1; n++;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " busy cycles"}, 32'(busy_n), (wr && !exp_err) ? 32'(SC) : 32'd0);
        check({name, " busy at rsp"}, 32'(attr_busy), 32'd0);
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1; req_write = 1'b1; req_idx = '0; req_wdata = '1;
            check({name, " hold ready"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        if (hold > 0) check_attr_all({name, " hold"});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, " valid drop"}, 32'(rsp_valid), 32'd0);
        check({name, " ready back"}, 32'(req_ready), 32'd1);
    endtask

    // Monitor: pop one expectation per response and compare every cycle it is presented
    initial begin
        exp_t cur;
        bit   seen;
        seen = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected rsp: got rdata %0h err %0h expected none", rsp_rdata, rsp_err);
                    end else begin
                        cur  = exp_q.pop_front();
                        seen = 1'b1;
                    end
                end
                if (seen) begin
                    check("rsp rdata", 32'(rsp_rdata), 32'(cur.rdata));
                    check("rsp err", 32'(rsp_err), 32'(cur.err));
                end
                if (rsp_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_idx = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        warl_mask = '1;
        for (int i = 0; i < NP; i++) model[i] = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset busy", 32'(attr_busy), 32'd0);
        check_attr_all("reset");

        do_req(1'b0, 4'd3, 13'h0000, 13'h0000, 1'b0, 1, 0, "rd3");
        set_mask(5, 13'h00FF);
        do_req(1'b1, 4'd5, 13'h1ABC, 13'h00BC, 1'b0, 5, 0, "wr5");
        do_req(1'b0, 4'd5, 13'h0000, 13'h00BC, 1'b0, 1, 0, "rd5");
        do_req(1'b1, 4'd13, 13'h1FFF, 13'h0000, 1'b1, 1, 0, "wr13");
        do_req(1'b1, 4'd12, 13'h0123, 13'h0000, 1'b1, 1, 0, "wr12");
        do_req(1'b0, 4'd15, 13'h0000, 13'h0000, 1'b1, 1, 0, "rd15");
        do_req(1'b1, 4'd11, 13'h1555, 13'h1555, 1'b0, 5, 6, "wr11 hold");
        set_mask(11, 13'h0000);
        do_req(1'b0, 4'd11, 13'h0000, 13'h1555, 1'b0, 1, 0, "rd11 newmask");
        do_req(1'b1, 4'd11, 13'h1FFF, 13'h0000, 1'b0, 5, 0, "wr11 masked");
        set_mask(11, 13'h1FFF);
        do_req(1'b1, 4'd0, 13'h0AAA, 13'h0AAA, 1'b0, 5, 2, "wr0 hold");

        // Reset in the middle of a write's settle window
        req_valid = 1'b1; req_write = 1'b1; req_idx = 4'd2; req_wdata = 13'h1FFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst pre attr2", 32'(attr_word(2)), 32'h1FFF);
        check("rst pre busy", 32'(attr_busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NP; i++) model[i] = '0;
        check("rst attr2", 32'(attr_word(2)), 32'd0);
        check("rst valid", 32'(rsp_valid), 32'd0);
        check("rst busy", 32'(attr_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post rst ready", 32'(req_ready), 32'd1);
        check("post rst valid", 32'(rsp_valid), 32'd0);
        check_attr_all("post rst");
        do_req(1'b0, 4'd5, 13'h0000, 13'h0000, 1'b0, 1, 0, "rd5 post rst");

`ifdef PAD_ATTR_CTRL_PARITY_EN
        do_req(1'b1, 4'd1, 13'h0003, 13'h0003, 1'b0, 5, 0, "wr1 par");
        check("parity_err clean", 32'(parity_err), 32'd0);
        force dut.attr_par_r[1] = 1'b1;
        do_req(1'b0, 4'd1, 13'h0000, 13'h0003, 1'b1, 1, 0, "rd1 bad par");
        release dut.attr_par_r[1];
        check("parity_err set", 32'(parity_err), 32'd1);
        do_req(1'b0, 4'd3, 13'h0000, 13'h0000, 1'b0, 1, 0, "rd3 par ok");
        check("parity_err sticky", 32'(parity_err), 32'd1);
`endif

        repeat (2) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
